// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment bit order, digit glyphs, and the
// small helpers used to turn decoded digits into a value and change event.
package seven_seg_pkg;

  // Bit positions inside a 7-bit pattern, ordered {A,B,C,D,E,F,G}
  localparam int SEG_W = 7;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high glyphs (1 = segment lit), matching the Binary_To_7Segment encoder
  localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_UP,
    EV_DOWN,
    EV_JUMP
  } change_e;

  // Two BCD digits to a 0..99 binary value
  function automatic logic [6:0] bcd_to_value(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

  // Classify a change of held value; no wrap between 99 and 0
  function automatic change_e classify_change(input logic [6:0] old_v, input logic [6:0] new_v);
    logic [7:0] w_old;
    logic [7:0] w_new;
    w_old = {1'b0, old_v};
    w_new = {1'b0, new_v};
    if (w_new == w_old + 8'd1)      return EV_UP;
    else if (w_new + 8'd1 == w_old) return EV_DOWN;
    else                            return EV_JUMP;
  endfunction

endpackage

// File: rtl/segment_digit_decode.sv
// Combinational decode of one active-high 7-segment glyph back to a BCD digit.
module segment_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] i_Pattern,
  output logic             o_Valid,
  output logic [3:0]       o_Digit
);

  // Exact match against the ten digit glyphs; anything else is undecodable
  always_comb begin
    o_Valid = 1'b1;
    o_Digit = 4'd0;
    case (i_Pattern)
      SEG_0:   o_Digit = 4'd0;
      SEG_1:   o_Digit = 4'd1;
      SEG_2:   o_Digit = 4'd2;
      SEG_3:   o_Digit = 4'd3;
      SEG_4:   o_Digit = 4'd4;
      SEG_5:   o_Digit = 4'd5;
      SEG_6:   o_Digit = 4'd6;
      SEG_7:   o_Digit = 4'd7;
      SEG_8:   o_Digit = 4'd8;
      SEG_9:   o_Digit = 4'd9;
      default: o_Valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a two-digit 7-segment display: synchronizes the pins,
// qualifies a stable pattern, decodes it and reports value-change events.
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [SEG_W-1:0] i_Segment1,
  input  logic [SEG_W-1:0] i_Segment2,
  output logic [3:0]       o_Tens,
  output logic [3:0]       o_Ones,
  output logic [6:0]       o_Value,
  output logic             o_Have_Value,
  output logic             o_Valid,
  output logic             o_Up,
  output logic             o_Down,
  output logic             o_Jump,
  output logic             o_Error,
  output logic             o_Blank
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

  logic [2*SEG_W-1:0] r_sync1;
  logic [2*SEG_W-1:0] r_sync2;
  logic [2*SEG_W-1:0] r_prev;
  logic [CNT_W-1:0]   r_cnt;

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [6:0] r_value;
  logic       r_have;
  logic       r_valid;
  logic       r_up;
  logic       r_down;
  logic       r_jump;
  logic       r_error;
  logic       r_blank;

  logic [2*SEG_W-1:0] w_pat;
  logic               w_match;
  logic               w_accept;
  logic               w_tens_ok;
  logic               w_ones_ok;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic [6:0]         w_new_value;
  change_e            w_change;

  // Pins are active-low; everything past the synchronizer works active-high
  assign w_pat    = ~r_sync2;
  assign w_match  = (w_pat == r_prev);
  assign w_accept = w_match && (r_cnt == CNT_ACC);

  // Two-flop synchronizer on all fourteen segment pins
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_Segment1, i_Segment2};
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter; saturating at STABLE_CYCLES keeps acceptance to one shot per pattern
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_pat;
      if (!w_match)
        r_cnt <= '0;
      else if (r_cnt != CNT_SAT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  segment_digit_decode u_tens_decode (
    .i_Pattern (w_pat[2*SEG_W-1:SEG_W]),
    .o_Valid   (w_tens_ok),
    .o_Digit   (w_tens)
  );

  segment_digit_decode u_ones_decode (
    .i_Pattern (w_pat[SEG_W-1:0]),
    .o_Valid   (w_ones_ok),
    .o_Digit   (w_ones)
  );

  assign w_new_value = bcd_to_value(w_tens, w_ones);
  assign w_change    = classify_change(r_value, w_new_value);

  // History register and event pulses, updated only on an accepted pattern
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tens  <= '0;
      r_ones  <= '0;
      r_value <= '0;
      r_have  <= 1'b0;
      r_valid <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_jump  <= 1'b0;
      r_error <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_jump  <= 1'b0;
      if (w_accept) begin
        if (w_tens_ok && w_ones_ok) begin
          r_error <= 1'b0;
          r_blank <= 1'b0;
          if (!r_have || (w_new_value != r_value)) begin
            r_tens  <= w_tens;
            r_ones  <= w_ones;
            r_value <= w_new_value;
            r_have  <= 1'b1;
            r_valid <= 1'b1;
            // The first value after reset has nothing to be compared against
            if (r_have) begin
              r_up   <= (w_change == EV_UP);
              r_down <= (w_change == EV_DOWN);
              r_jump <= (w_change == EV_JUMP);
            end
          end
        end else if (w_pat == {SEG_BLANK, SEG_BLANK}) begin
          r_blank <= 1'b1;
          r_error <= 1'b0;
        end else begin
          r_error <= 1'b1;
          r_blank <= 1'b0;
        end
      end
    end
  end

  assign o_Tens       = r_tens;
  assign o_Ones       = r_ones;
  assign o_Value      = r_value;
  assign o_Have_Value = r_have;
  assign o_Valid      = r_valid;
  assign o_Up         = r_up;
  assign o_Down       = r_down;
  assign o_Jump       = r_jump;
  assign o_Error      = r_error;
  assign o_Blank      = r_blank;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture with a small display-level reference model.
module tb_seven_segment_capture;

  localparam int S   = 4;
  localparam int LAT = S + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [3:0] o_Tens;
  logic [3:0] o_Ones;
  logic [6:0] o_Value;
  logic       o_Have_Value;
  logic       o_Valid;
  logic       o_Up;
  logic       o_Down;
  logic       o_Jump;
  logic       o_Error;
  logic       o_Blank;

  int checks = 0;
  int failures = 0;

  // Glyph tables, active-high {A..G}
  logic [6:0] dig_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [6:0] hex_pat [6]  = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state: what the display monitor should be holding
  bit m_have;
  int m_value;
  bit m_err;
  bit m_blank;

  seven_segment_capture #(.STABLE_CYCLES(S)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Segment1   (seg1),
    .i_Segment2   (seg2),
    .o_Tens       (o_Tens),
    .o_Ones       (o_Ones),
    .o_Value      (o_Value),
    .o_Have_Value (o_Have_Value),
    .o_Valid      (o_Valid),
    .o_Up         (o_Up),
    .o_Down       (o_Down),
    .o_Jump       (o_Jump),
    .o_Error      (o_Error),
    .o_Blank      (o_Blank)
  );

  always #5 clk = ~clk;

  function automatic int dec(input logic [6:0] p);
    int r;
    r = -1;
    for (int i = 0; i < 10; i++)
      if (p == dig_pat[i]) r = i;
    return r;
  endfunction

  // Drive a pattern (active-high view) and check the display's response over the full latency window
  task automatic apply(input logic [6:0] tp, input logic [6:0] op, input string name);
    int   t, o, nv;
    bit   ev, up, dn, jp, stray;
    logic got_v, got_u, got_d, got_j;
    ev = 0; up = 0; dn = 0; jp = 0; stray = 0;
    got_v = 0; got_u = 0; got_d = 0; got_j = 0;
    t = dec(tp);
    o = dec(op);
    if (t >= 0 && o >= 0) begin
      nv = t * 10 + o;
      if (!m_have || nv != m_value) begin
        ev = 1;
        if (m_have) begin
          up = (nv == m_value + 1);
          dn = (nv == m_value - 1);
          jp = !up && !dn;
        end
        m_have  = 1;
        m_value = nv;
      end
      m_err = 0; m_blank = 0;
    end else if (tp == 7'h00 && op == 7'h00) begin
      m_blank = 1; m_err = 0;
    end else begin
      m_err = 1; m_blank = 0;
    end
    seg1 = ~tp;
    seg2 = ~op;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      if (k == LAT) begin
        got_v = o_Valid; got_u = o_Up; got_d = o_Down; got_j = o_Jump;
      end else if (o_Valid || o_Up || o_Down || o_Jump) begin
        stray = 1;
      end
    end
    checks++; if (got_v !== ev) begin failures++; $display("FAIL %s valid_at_lat: got %0b exp %0b", name, got_v, ev); end
    checks++; if (got_u !== up) begin failures++; $display("FAIL %s up: got %0b exp %0b", name, got_u, up); end
    checks++; if (got_d !== dn) begin failures++; $display("FAIL %s down: got %0b exp %0b", name, got_d, dn); end
    checks++; if (got_j !== jp) begin failures++; $display("FAIL %s jump: got %0b exp %0b", name, got_j, jp); end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL %s stray_pulse: got %0b exp 0", name, stray); end
    checks++; if (o_Value !== 7'(m_value)) begin failures++; $display("FAIL %s value: got %0d exp %0d", name, o_Value, m_value); end
    checks++; if (o_Tens !== 4'(m_value / 10)) begin failures++; $display("FAIL %s tens: got %0d exp %0d", name, o_Tens, m_value / 10); end
    checks++; if (o_Ones !== 4'(m_value % 10)) begin failures++; $display("FAIL %s ones: got %0d exp %0d", name, o_Ones, m_value % 10); end
    checks++; if (o_Have_Value !== m_have) begin failures++; $display("FAIL %s have: got %0b exp %0b", name, o_Have_Value, m_have); end
    checks++; if (o_Error !== m_err) begin failures++; $display("FAIL %s error: got %0b exp %0b", name, o_Error, m_err); end
    checks++; if (o_Blank !== m_blank) begin failures++; $display("FAIL %s blank: got %0b exp %0b", name, o_Blank, m_blank); end
  endtask

  task automatic test_reset();
    seg1 = 7'h7F;
    seg2 = 7'h7F;
    rst_n = 1'b0;
    m_have = 0; m_value = 0; m_err = 0; m_blank = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({o_Have_Value, o_Valid, o_Up, o_Down, o_Jump, o_Error, o_Blank} !== 7'b0) begin
      failures++; $display("FAIL reset_flags: got %b exp 0000000", {o_Have_Value, o_Valid, o_Up, o_Down, o_Jump, o_Error, o_Blank});
    end
    checks++; if (o_Value !== 7'd0) begin failures++; $display("FAIL reset_value: got %0d exp 0", o_Value); end
    checks++; if ({o_Tens, o_Ones} !== 8'h00) begin failures++; $display("FAIL reset_digits: got %h exp 00", {o_Tens, o_Ones}); end
  endtask

  task automatic test_first_value();
    rst_n = 1'b1;
    apply(dig_pat[4], dig_pat[2], "first_42");
  endtask

  task automatic test_up_down_jump();
    apply(dig_pat[4], dig_pat[3], "up_43");
    apply(dig_pat[4], dig_pat[2], "down_42");
    apply(dig_pat[1], dig_pat[5], "jump_15");
  endtask

  task automatic test_glitch();
    bit stray;
    stray = 0;
    apply(dig_pat[0], dig_pat[7], "at_07");
    seg2 = ~dig_pat[7] ^ 7'b0100000;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_Valid || o_Up || o_Down || o_Jump) stray = 1;
    end
    seg2 = ~dig_pat[7];
    repeat (3 * LAT) begin
      @(posedge clk); #1;
      if (o_Valid || o_Up || o_Down || o_Jump) stray = 1;
    end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL glitch_pulse: got %0b exp 0", stray); end
    checks++; if (o_Value !== 7'd7) begin failures++; $display("FAIL glitch_value: got %0d exp 7", o_Value); end
    checks++; if (o_Error !== 1'b0) begin failures++; $display("FAIL glitch_error: got %0b exp 0", o_Error); end
  endtask

  task automatic test_error();
    apply(7'h77, dig_pat[7], "tens_hexA");
    apply(dig_pat[0], dig_pat[8], "after_err_08");
  endtask

  task automatic test_blank();
    apply(7'h00, 7'h00, "dark");
    apply(dig_pat[0], dig_pat[0], "val_00");
    apply(dig_pat[9], dig_pat[9], "wrap_99");
  endtask

  task automatic test_reset_mid();
    seg1 = ~dig_pat[5];
    seg2 = ~dig_pat[0];
    repeat (4) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    checks++; if ({o_Have_Value, o_Valid, o_Up, o_Down, o_Jump, o_Error, o_Blank} !== 7'b0) begin
      failures++; $display("FAIL midrst_flags: got %b exp 0000000", {o_Have_Value, o_Valid, o_Up, o_Down, o_Jump, o_Error, o_Blank});
    end
    checks++; if (o_Value !== 7'd0) begin failures++; $display("FAIL midrst_value: got %0d exp 0", o_Value); end
    m_have = 0; m_value = 0; m_err = 0; m_blank = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(dig_pat[5], dig_pat[0], "after_rst_50");
  endtask

  task automatic test_random();
    int         sel, v;
    logic [6:0] tp, op;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      v = $urandom_range(0, 99);
      if (sel >= 4 && sel <= 5 && m_value < 99) v = m_value + 1;
      if (sel >= 6 && sel <= 7 && m_value > 0)  v = m_value - 1;
      tp = dig_pat[v / 10];
      op = dig_pat[v % 10];
      if (sel == 8) begin
        if ($urandom_range(0, 1) == 0) tp = hex_pat[$urandom_range(0, 5)];
        else                           op = hex_pat[$urandom_range(0, 5)];
      end
      if (sel == 9) begin
        tp = 7'h00;
        op = 7'h00;
      end
      apply(tp, op, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_first_value();
    test_up_down_jump();
    test_glitch();
    test_error();
    test_blank();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
